// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte-addressed load/store requests to a word-addressed data memory.
// Sub-word stores are done as read-modify-write. All control outputs are registered;
// only ReqReady and the two memory strobes are gated combinationally by Rst_n.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqOp,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWrData,
    output logic        RespValid,
    output logic        RespErr,
    output logic [31:0] RespData,
    output logic [15:0] AccessCount,
    output logic        DmemRead,
    output logic        DmemWrite,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWrData,
    input  logic [31:0] DmemRdData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    logic [2:0]  opQ;
    logic [1:0]  addrLoQ;
    logic [31:0] wrDataQ;
    logic        dmemReadQ;
    logic        dmemWriteQ;
    logic [15:0] accessCnt;

    logic        reqErr;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] ldData;
    logic [31:0] mergeData;

    assign ReqReady    = (state == IDLE) & Rst_n;
    assign DmemRead    = dmemReadQ & Rst_n;
    assign DmemWrite   = dmemWriteQ & Rst_n;
    assign AccessCount = accessCnt;

    // Request legality: illegal size, misalignment, or address beyond memory depth
    always_comb begin
        reqErr = (ReqOp[1:0] == 2'b11)
               | ((ReqOp[1:0] == 2'b01) & ReqAddr[0])
               | ((ReqOp[1:0] == 2'b10) & (|ReqAddr[1:0]))
               | (|ReqAddr[31:ADDR_WIDTH+2]);
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        case (addrLoQ)
            2'd0:    ldByte = DmemRdData[7:0];
            2'd1:    ldByte = DmemRdData[15:8];
            2'd2:    ldByte = DmemRdData[23:16];
            default: ldByte = DmemRdData[31:24];
        endcase
        ldHalf = addrLoQ[1] ? DmemRdData[31:16] : DmemRdData[15:0];

        ldData = DmemRdData;
        if (opQ[1:0] == 2'b00)
            ldData = {{24{~opQ[2] & ldByte[7]}}, ldByte};
        else if (opQ[1:0] == 2'b01)
            ldData = {{16{~opQ[2] & ldHalf[15]}}, ldHalf};

        mergeData = DmemRdData;
        if (opQ[1:0] == 2'b00) begin
            case (addrLoQ)
                2'd0:    mergeData[7:0]   = wrDataQ[7:0];
                2'd1:    mergeData[15:8]  = wrDataQ[7:0];
                2'd2:    mergeData[23:16] = wrDataQ[7:0];
                default: mergeData[31:24] = wrDataQ[7:0];
            endcase
        end else if (addrLoQ[1]) begin
            mergeData[31:16] = wrDataQ[15:0];
        end else begin
            mergeData[15:0] = wrDataQ[15:0];
        end
    end

    // Access sequencer with registered response and memory-port outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            opQ        <= '0;
            addrLoQ    <= '0;
            wrDataQ    <= '0;
            RespValid  <= 1'b0;
            RespErr    <= 1'b0;
            RespData   <= '0;
            accessCnt  <= '0;
            dmemReadQ  <= 1'b0;
            dmemWriteQ <= 1'b0;
            DmemAddr   <= '0;
            DmemWrData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        opQ      <= ReqOp;
                        addrLoQ  <= ReqAddr[1:0];
                        wrDataQ  <= ReqWrData;
                        RespData <= '0;
                        if (reqErr) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespErr   <= 1'b1;
                        end else begin
                            DmemAddr <= {{(32-ADDR_WIDTH){1'b0}}, ReqAddr[ADDR_WIDTH+1:2]};
                            if (!ReqWrite) begin
                                state     <= LOAD;
                                dmemReadQ <= 1'b1;
                            end else if (ReqOp[1:0] == 2'b10) begin
                                state      <= WRITE;
                                dmemWriteQ <= 1'b1;
                                DmemWrData <= ReqWrData;
                            end else begin
                                state     <= RMW_RD;
                                dmemReadQ <= 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    RespData  <= ldData;
                    dmemReadQ <= 1'b0;
                    DmemAddr  <= '0;
                    RespValid <= 1'b1;
                    accessCnt <= accessCnt + 16'd1;
                    state     <= RESP;
                end
                RMW_RD: begin
                    DmemWrData <= mergeData;
                    dmemReadQ  <= 1'b0;
                    dmemWriteQ <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    dmemWriteQ <= 1'b0;
                    DmemAddr   <= '0;
                    DmemWrData <= '0;
                    RespValid  <= 1'b1;
                    accessCnt  <= accessCnt + 16'd1;
                    state      <= RESP;
                end
                RESP: begin
                    RespValid <= 1'b0;
                    RespErr   <= 1'b0;
                    RespData  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed load/store/error/reset vectors against a small memory model.
module tb_dmem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [2:0]  ReqOp = '0;
    logic [31:0] ReqAddr = '0;
    logic [31:0] ReqWrData = '0;
    logic        RespValid;
    logic        RespErr;
    logic [31:0] RespData;
    logic [15:0] AccessCount;
    logic        DmemRead;
    logic        DmemWrite;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWrData;
    logic [31:0] DmemRdData;

    dmem_access_unit #(.ADDR_WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqWrData(ReqWrData),
        .RespValid(RespValid), .RespErr(RespErr), .RespData(RespData),
        .AccessCount(AccessCount), .DmemRead(DmemRead), .DmemWrite(DmemWrite),
        .DmemAddr(DmemAddr), .DmemWrData(DmemWrData), .DmemRdData(DmemRdData)
    );

    always #5 Clk = ~Clk;

    // Word memory: combinational read, posedge write; bench preload has priority
    logic [31:0] mem [256];
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeIdx = '0;
    logic [31:0] pokeVal = '0;
    assign DmemRdData = mem[DmemAddr[7:0]];
    always @(posedge Clk) begin
        if (pokeEn)         mem[pokeIdx] <= pokeVal;
        else if (DmemWrite) mem[DmemAddr[7:0]] <= DmemWrData;
    end
    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    // Strobe monitor sampled on the falling edge
    int          rdCnt = 0;
    int          wrCnt = 0;
    int          overlap = 0;
    logic [31:0] lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    always @(negedge Clk) begin
        if (DmemRead) rdCnt++;
        if (DmemWrite) begin
            wrCnt++;
            lastWrAddr = DmemAddr;
            lastWrData = DmemWrData;
        end
        if (DmemRead && DmemWrite) overlap++;
    end

    int checkCnt = 0;
    int passCnt  = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            passCnt++;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge Clk);
        pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
        @(posedge Clk);
        #1 pokeEn = 1'b0;
    endtask

    // Issue one request from IDLE and wait (bounded) for its response
    task automatic runReq(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] data,
                          output logic err, output int lat);
        @(negedge Clk);
        rdCnt = 0; wrCnt = 0;
        ReqWrite = wr; ReqOp = op; ReqAddr = addr; ReqWrData = wdata; ReqValid = 1'b1;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        lat = 0;
        data = '0;
        err = 1'b0;
        while (lat < 10) begin
            @(negedge Clk);
            lat++;
            if (RespValid) begin
                data = RespData;
                err  = RespErr;
                break;
            end
        end
        if (!RespValid) checkEq("resp_timeout", 32'(lat), 32'd0);
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;
    logic [15:0] cntSave;
    logic [5:0]  readyBits;
    logic [5:0]  respBits;
    int          accepted;

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] exp;
    } ldVec_t;
    ldVec_t ldVecs[5];

    typedef struct {
        string       tag;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
    } errVec_t;
    errVec_t errVecs[4];

    initial begin
        ldVecs[0] = '{"lb_0x13",  3'b000, 32'h13, 32'hFFFFFFAA};
        ldVecs[1] = '{"lbu_0x13", 3'b100, 32'h13, 32'h000000AA};
        ldVecs[2] = '{"lh_0x12",  3'b001, 32'h12, 32'hFFFFAA22};
        ldVecs[3] = '{"lhu_0x12", 3'b101, 32'h12, 32'h0000AA22};
        ldVecs[4] = '{"lh_0x10",  3'b001, 32'h10, 32'h00003344};
        errVecs[0] = '{"err_lw_0x11",  1'b0, 3'b010, 32'h11};
        errVecs[1] = '{"err_sh_0x13",  1'b1, 3'b001, 32'h13};
        errVecs[2] = '{"err_size11",   1'b0, 3'b011, 32'h10};
        errVecs[3] = '{"err_lw_0x400", 1'b0, 3'b010, 32'h400};

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkEq("rst_ready", 32'(ReqReady), 32'd0);
        checkEq("rst_respvalid", 32'(RespValid), 32'd0);
        checkEq("rst_count", 32'(AccessCount), 32'd0);
        checkEq("rst_strobes", {30'd0, DmemRead, DmemWrite}, 32'd0);
        checkEq("rst_addr", DmemAddr, 32'd0);
        Rst_n = 1'b1;
        #1 checkEq("ready_after_release", 32'(ReqReady), 32'd1);

        // SW then LW of a full word
        runReq(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat);
        checkEq("sw_lat", 32'(lat), 32'd2);
        checkEq("sw_err", 32'(e), 32'd0);
        checkEq("sw_data", d, 32'd0);
        checkEq("sw_wrcnt", 32'(wrCnt), 32'd1);
        checkEq("sw_rdcnt", 32'(rdCnt), 32'd0);
        checkEq("sw_addr", lastWrAddr, 32'd4);
        checkEq("sw_mem", mem[4], 32'hDEADBEEF);
        checkEq("idle_addr", DmemAddr, 32'd0);
        checkEq("idle_wrdata", DmemWrData, 32'd0);
        runReq(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
        checkEq("lw_lat", 32'(lat), 32'd2);
        checkEq("lw_data", d, 32'hDEADBEEF);
        checkEq("lw_rdcnt", 32'(rdCnt), 32'd1);
        checkEq("count_after_2", 32'(AccessCount), 32'd2);

        // SB via read-modify-write
        poke(8'd4, 32'h11223344);
        runReq(1'b1, 3'b000, 32'h13, 32'h000000AA, d, e, lat);
        checkEq("sb_lat", 32'(lat), 32'd3);
        checkEq("sb_rdcnt", 32'(rdCnt), 32'd1);
        checkEq("sb_wrcnt", 32'(wrCnt), 32'd1);
        checkEq("sb_merged", lastWrData, 32'hAA223344);
        checkEq("sb_mem", mem[4], 32'hAA223344);

        // Sub-word loads with sign/zero extension
        foreach (ldVecs[i]) begin
            runReq(1'b0, ldVecs[i].op, ldVecs[i].addr, 32'h0, d, e, lat);
            checkEq(ldVecs[i].tag, d, ldVecs[i].exp);
            checkEq({ldVecs[i].tag, "_lat"}, 32'(lat), 32'd2);
        end

        // Error requests: no strobes, count unchanged
        cntSave = AccessCount;
        foreach (errVecs[i]) begin
            runReq(errVecs[i].wr, errVecs[i].op, errVecs[i].addr, 32'h5A5A5A5A, d, e, lat);
            checkEq(errVecs[i].tag, 32'(e), 32'd1);
            checkEq({errVecs[i].tag, "_lat"}, 32'(lat), 32'd1);
            checkEq({errVecs[i].tag, "_strobes"}, 32'(rdCnt + wrCnt), 32'd0);
            checkEq({errVecs[i].tag, "_data"}, d, 32'd0);
        end
        checkEq("err_count_same", 32'(AccessCount), 32'(cntSave));
        checkEq("mem4_after_err", mem[4], 32'hAA223344);

        // Reset asserted during the WRITE cycle of SW
        poke(8'd8, 32'h12345678);
        @(negedge Clk);
        ReqWrite = 1'b1; ReqOp = 3'b010; ReqAddr = 32'h20; ReqWrData = 32'h55; ReqValid = 1'b1;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        checkEq("write_strobe_pre_rst", 32'(DmemWrite), 32'd1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1 checkEq("write_gated_by_rst", 32'(DmemWrite), 32'd0);
        checkEq("ready_in_rst", 32'(ReqReady), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1 checkEq("ready_after_abort", 32'(ReqReady), 32'd1);
        checkEq("resp_after_abort", 32'(RespValid), 32'd0);
        checkEq("mem8_unchanged", mem[8], 32'h12345678);
        checkEq("count_after_rst", 32'(AccessCount), 32'd0);

        // Back-to-back with ReqValid held, and counter wrap
        @(negedge Clk);
        dut.accessCnt = 16'hFFFF;
        ReqWrite = 1'b0; ReqOp = 3'b010; ReqAddr = 32'h10; ReqWrData = 32'h0; ReqValid = 1'b1;
        accepted = 0;
        readyBits = '0;
        respBits = '0;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) @(negedge Clk);
            #1;
            readyBits[n] = ReqReady;
            respBits[n]  = RespValid;
            if (ReqReady && ReqValid) accepted++;
            if (n == 2) begin
                checkEq("b2b_lw_data", RespData, 32'hAA223344);
                checkEq("count_wrap", 32'(AccessCount), 32'd0);
                ReqWrite = 1'b1; ReqOp = 3'b010; ReqAddr = 32'h24; ReqWrData = 32'h77;
            end
            if (n == 5) begin
                checkEq("count_after_wrap", 32'(AccessCount), 32'd1);
                ReqValid = 1'b0;
            end
        end
        checkEq("b2b_ready_pattern", 32'(readyBits), 32'b001001);
        checkEq("b2b_resp_pattern", 32'(respBits), 32'b100100);
        checkEq("b2b_accepted", 32'(accepted), 32'd2);
        @(negedge Clk);
        checkEq("b2b_sw_mem", mem[9], 32'h77);
        checkEq("no_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
